// File: rtl/dps_lsflags_if.sv
// Bus bundle between the CPU/peripheral side and the LSFLAGS interrupt source stage.
// Carries event pulses, mask write, read-and-clear request, read data, mask readback and IRQ/ACK.
// master = driver side (peripherals, CPU, arbiter); slave = dps_lsflags.
interface dps_lsflags_if #(
   parameter int P_N = 8
);
   logic [P_N-1:0]   iEVENT;
   logic             iCONF_WR;
   logic [P_N-1:0]   iCONF_DATA;
   logic             iFLAGS_RD;
   logic             oFLAGS_VALID;
   logic [2*P_N-1:0] oFLAGS_DATA;
   logic [P_N-1:0]   oMASK;
   logic             oIRQ;
   logic             iACK;

   modport master (
      output iEVENT, iCONF_WR, iCONF_DATA, iFLAGS_RD, iACK,
      input  oFLAGS_VALID, oFLAGS_DATA, oMASK, oIRQ
   );

   modport slave (
      input  iEVENT, iCONF_WR, iCONF_DATA, iFLAGS_RD, iACK,
      output oFLAGS_VALID, oFLAGS_DATA, oMASK, oIRQ
   );
endinterface

// File: rtl/dps_lsflags.sv
// Purpose: sticky event flags + overrun, enable mask, level IRQ to the DPS arbiter, read-and-clear.
// Latency: event -> flag after 1 edge, oIRQ after 2 edges; read data valid 1 cycle after iFLAGS_RD.
// Backpressure: none; events sampled every cycle, oIRQ held until iACK or withdrawn (pend=0).
// Ports: iCLOCK, inRESET (async active-low), iRESET_SYNC (sync clear), bus (dps_lsflags_if.slave):
//    iEVENT/iCONF_WR/iCONF_DATA/iFLAGS_RD/iACK in, oFLAGS_VALID/oFLAGS_DATA/oMASK/oIRQ out.
module dps_lsflags #(
   parameter int P_N = 8
) (
   input  logic           iCLOCK,
   input  logic           inRESET,
   input  logic           iRESET_SYNC,
   dps_lsflags_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t           state;
   state_t           stateNext;
   logic [P_N-1:0]   flags;
   logic [P_N-1:0]   overrun;
   logic [P_N-1:0]   mask;
   logic             flagsValid;
   logic [2*P_N-1:0] flagsData;
   logic             pend;

   // Pending is taken from registered flags and mask only, so no input reaches oIRQ combinationally.
   assign pend = |(flags & mask);

   // Flags, overrun, mask and read-data registers.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         flags      <= '0;
         overrun    <= '0;
         mask       <= '0;
         flagsValid <= 1'b0;
         flagsData  <= '0;
      end else if (iRESET_SYNC) begin
         flags      <= '0;
         overrun    <= '0;
         mask       <= '0;
         flagsValid <= 1'b0;
         flagsData  <= '0;
      end else begin
         flagsValid <= bus.iFLAGS_RD;
         if (bus.iFLAGS_RD) begin
            // Snapshot is pre-edge state; a same-cycle event survives the clear.
            flagsData <= {overrun, flags};
            flags     <= bus.iEVENT;
            overrun   <= '0;
         end else begin
            flags   <= flags | bus.iEVENT;
            overrun <= overrun | (flags & bus.iEVENT);
         end
         if (bus.iCONF_WR) begin
            mask <= bus.iCONF_DATA;
         end
      end
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state <= IDLE;
      end else if (iRESET_SYNC) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (pend) stateNext = REQ;
         end
         REQ: begin
            // ACK wins over a withdrawal arriving in the same cycle.
            if (bus.iACK)  stateNext = SERVICE;
            else if (!pend) stateNext = IDLE;
         end
         SERVICE: begin
            // Going through IDLE lets a concurrent new event re-raise one cycle later.
            if (bus.iFLAGS_RD) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign bus.oIRQ         = (state == REQ);
   assign bus.oMASK        = mask;
   assign bus.oFLAGS_VALID = flagsValid;
   assign bus.oFLAGS_DATA  = flagsData;

endmodule

// File: tb/tb_dps_lsflags.sv
// Randomized + directed bench for dps_lsflags against a per-bit behavioural model.
// Latency: model advances once per clock edge; outputs compared 1 time unit after each edge.
// Backpressure: none; the bench drives ACK and reads freely.
module tb_dps_lsflags;
   localparam int P_N = 8;

   logic iCLOCK = 1'b0;
   logic inRESET = 1'b0;
   logic iRESET_SYNC = 1'b0;

   dps_lsflags_if #(.P_N(P_N)) bus ();

   dps_lsflags #(.P_N(P_N)) dut (
      .iCLOCK      (iCLOCK),
      .inRESET     (inRESET),
      .iRESET_SYNC (iRESET_SYNC),
      .bus         (bus)
   );

   always #5 iCLOCK = ~iCLOCK;

   int nChecks = 0;
   int nFail   = 0;

   // Reference model: one boolean per source, IRQ condition as two booleans.
   bit             mFlag [P_N];
   bit             mOver [P_N];
   logic [P_N-1:0] mMask;
   bit             mIrq;
   bit             mSvc;
   bit             mVld;
   logic [15:0]    mData;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFail++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < P_N; k++) begin
         mFlag[k] = 0;
         mOver[k] = 0;
      end
      mMask = '0;
      mIrq  = 0;
      mSvc  = 0;
      mVld  = 0;
      mData = '0;
   endtask

   function automatic logic [P_N-1:0] packFlags();
      logic [P_N-1:0] v;
      for (int k = 0; k < P_N; k++) v[k] = mFlag[k];
      return v;
   endfunction

   function automatic logic [P_N-1:0] packOver();
      logic [P_N-1:0] v;
      for (int k = 0; k < P_N; k++) v[k] = mOver[k];
      return v;
   endfunction

   task automatic modelStep();
      bit pend;
      if (iRESET_SYNC) begin
         modelReset();
         return;
      end
      pend = 0;
      for (int k = 0; k < P_N; k++) if (mFlag[k] && mMask[k]) pend = 1;
      if (mIrq) begin
         if (bus.iACK) begin
            mIrq = 0;
            mSvc = 1;
         end else if (!pend) begin
            mIrq = 0;
         end
      end else if (mSvc) begin
         if (bus.iFLAGS_RD) mSvc = 0;
      end else if (pend) begin
         mIrq = 1;
      end
      mVld = bus.iFLAGS_RD;
      if (bus.iFLAGS_RD) mData = {packOver(), packFlags()};
      for (int k = 0; k < P_N; k++) begin
         if (bus.iFLAGS_RD) begin
            mOver[k] = 0;
            mFlag[k] = bus.iEVENT[k];
         end else begin
            if (bus.iEVENT[k] && mFlag[k]) mOver[k] = 1;
            if (bus.iEVENT[k]) mFlag[k] = 1;
         end
      end
      if (bus.iCONF_WR) mMask = bus.iCONF_DATA;
   endtask

   task automatic setIn(input logic [7:0] ev, input logic wr, input logic [7:0] cd,
                        input logic rd, input logic ack);
      bus.iEVENT     = ev;
      bus.iCONF_WR   = wr;
      bus.iCONF_DATA = cd;
      bus.iFLAGS_RD  = rd;
      bus.iACK       = ack;
   endtask

   // One clock: model consumes the inputs present at the edge, then outputs are compared.
   task automatic cyc();
      @(posedge iCLOCK);
      modelStep();
      #1;
      check("irq",   32'(bus.oIRQ),         32'(mIrq));
      check("vld",   32'(bus.oFLAGS_VALID), 32'(mVld));
      check("data",  32'(bus.oFLAGS_DATA),  32'(mData));
      check("mask",  32'(bus.oMASK),        32'(mMask));
      setIn(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      iRESET_SYNC = 1'b0;
   endtask

   task automatic step(input logic [7:0] ev, input logic wr, input logic [7:0] cd,
                       input logic rd, input logic ack);
      setIn(ev, wr, cd, rd, ack);
      cyc();
   endtask

   initial begin
      setIn(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      modelReset();
      #12;
      check("rst_irq",  32'(bus.oIRQ),         32'd0);
      check("rst_vld",  32'(bus.oFLAGS_VALID), 32'd0);
      check("rst_data", 32'(bus.oFLAGS_DATA),  32'd0);
      check("rst_mask", 32'(bus.oMASK),        32'd0);
      inRESET = 1'b1;
      cyc();

      // 1: single event, ACK, read
      step(8'h00, 1, 8'hFF, 0, 0);
      step(8'h04, 0, 8'h00, 0, 0);
      check("t1_irq_lat1", 32'(bus.oIRQ), 32'd0);
      cyc();
      check("t1_irq_up", 32'(bus.oIRQ), 32'd1);
      step(8'h00, 0, 8'h00, 0, 1);
      check("t1_ack", 32'(bus.oIRQ), 32'd0);
      cyc();
      check("t1_svc_hold", 32'(bus.oIRQ), 32'd0);
      step(8'h00, 0, 8'h00, 1, 0);
      check("t1_rd_vld", 32'(bus.oFLAGS_VALID), 32'd1);
      check("t1_rd_dat", 32'(bus.oFLAGS_DATA), 32'h0004);
      cyc();
      check("t1_idle", 32'(bus.oIRQ), 32'd0);

      // 2: masked flag, then enable it
      step(8'h00, 1, 8'h00, 0, 0);
      step(8'h01, 0, 8'h00, 0, 0);
      cyc();
      cyc();
      check("t2_masked", 32'(bus.oIRQ), 32'd0);
      step(8'h00, 1, 8'h01, 0, 0);
      check("t2_wr_edge", 32'(bus.oIRQ), 32'd0);
      cyc();
      check("t2_irq", 32'(bus.oIRQ), 32'd1);
      step(8'h00, 0, 8'h00, 0, 1);
      step(8'h00, 0, 8'h00, 1, 0);
      check("t2_rd", 32'(bus.oFLAGS_DATA), 32'h0001);

      // 3: overrun and back-to-back reads
      step(8'h10, 0, 8'h00, 0, 0);
      step(8'h10, 0, 8'h00, 0, 0);
      step(8'h00, 0, 8'h00, 1, 0);
      check("t3_ovr", 32'(bus.oFLAGS_DATA), 32'h1010);
      step(8'h00, 0, 8'h00, 1, 0);
      check("t3_empty", 32'(bus.oFLAGS_DATA), 32'h0000);
      check("t3_vld", 32'(bus.oFLAGS_VALID), 32'd1);
      cyc();
      check("t3_vld_drop", 32'(bus.oFLAGS_VALID), 32'd0);
      check("t3_hold", 32'(bus.oFLAGS_DATA), 32'h0000);

      // 4: read with concurrent event in SERVICE
      step(8'h00, 1, 8'hFF, 0, 0);
      step(8'h01, 0, 8'h00, 0, 0);
      cyc();
      step(8'h00, 0, 8'h00, 0, 1);
      step(8'h02, 0, 8'h00, 1, 0);
      check("t4_rd", 32'(bus.oFLAGS_DATA), 32'h0001);
      check("t4_irq_low", 32'(bus.oIRQ), 32'd0);
      cyc();
      check("t4_reraise", 32'(bus.oIRQ), 32'd1);
      step(8'h00, 0, 8'h00, 0, 1);
      step(8'h00, 0, 8'h00, 1, 0);
      check("t4_rd2", 32'(bus.oFLAGS_DATA), 32'h0002);

      // 5: withdrawal by mask clear, and ACK priority
      step(8'h01, 0, 8'h00, 0, 0);
      cyc();
      step(8'h00, 1, 8'h00, 0, 0);
      check("t5_still_req", 32'(bus.oIRQ), 32'd1);
      cyc();
      check("t5_withdrawn", 32'(bus.oIRQ), 32'd0);
      step(8'h00, 1, 8'hFF, 0, 0);
      cyc();
      check("t5_req2", 32'(bus.oIRQ), 32'd1);
      step(8'h00, 1, 8'h00, 0, 1);
      step(8'h00, 1, 8'hFF, 0, 0);
      cyc();
      check("t5_svc", 32'(bus.oIRQ), 32'd0);
      step(8'h00, 0, 8'h00, 1, 0);
      cyc();

      // 6: async reset in REQ
      step(8'hFF, 0, 8'h00, 0, 0);
      cyc();
      check("t6_req", 32'(bus.oIRQ), 32'd1);
      inRESET = 1'b0;
      #2;
      modelReset();
      check("t6_irq",  32'(bus.oIRQ),         32'd0);
      check("t6_mask", 32'(bus.oMASK),        32'd0);
      check("t6_vld",  32'(bus.oFLAGS_VALID), 32'd0);
      check("t6_data", 32'(bus.oFLAGS_DATA),  32'd0);
      #3;
      inRESET = 1'b1;
      cyc();
      cyc();
      check("t6_quiet", 32'(bus.oIRQ), 32'd0);
      step(8'h01, 0, 8'h00, 0, 0);
      cyc();
      check("t6_nomask", 32'(bus.oIRQ), 32'd0);
      step(8'h00, 1, 8'hFF, 0, 0);
      cyc();
      check("t6_irq_back", 32'(bus.oIRQ), 32'd1);

      // Random traffic, including occasional synchronous clears.
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] ev;
         logic       wr;
         logic       rd;
         logic       ack;
         ev  = 8'($urandom) & 8'($urandom) & 8'($urandom);
         wr  = ($urandom_range(0, 9) == 0);
         rd  = ($urandom_range(0, 6) == 0);
         ack = mIrq ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
         iRESET_SYNC = ($urandom_range(0, 99) == 0);
         step(ev, wr, 8'($urandom), rd, ack);
      end

      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
      $finish;
   end
endmodule
